// File: rtl/led_fade_pwm.sv
// LED fade/PWM stage: ramps brightness toward led_in ? level_max : 0 and renders it as PWM.
// Optional LED_FADE_GAMMA_EN squares the level (gamma ~2) before the PWM compare.
module led_fade_pwm #(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  output logic                reset__ack,
  input  logic                led_in,
  input  logic [PWM_BITS-1:0] level_max,
  output logic                led,
  output logic [PWM_BITS-1:0] level,
  output logic                busy
);

  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0]       T_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0]       T_ONE  = TW'(1);
  localparam logic [PWM_BITS-1:0] ONE    = PWM_BITS'(1);

  typedef enum logic [1:0] {OFF, UP, ON, DOWN} state_e;

  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                led_q, led_d;
  logic                busy_q, busy_d;
  logic                reset_ack_q;
  logic [PWM_BITS-1:0] target, duty;
  logic                expire;

  assign target = led_in ? level_max : '0;
  assign expire = (timer_q == T_LAST);

  // A direction change always wins over a pending step, so the level never overshoots.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      OFF: if (target != '0) state_d = UP;
      UP: begin
        if (target < level_q)       state_d = DOWN;
        else if (target == level_q) state_d = (level_q == '0) ? OFF : ON;
        else if (expire) begin
          level_d = level_q + ONE;
          if (level_q + ONE == target) state_d = ON;
        end
      end
      ON: begin
        if (target > level_q)      state_d = UP;
        else if (target < level_q) state_d = DOWN;
      end
      DOWN: begin
        if (target > level_q)       state_d = UP;
        else if (target == level_q) state_d = (target == '0) ? OFF : ON;
        else if (expire) begin
          level_d = level_q - ONE;
          if (level_q - ONE == target) state_d = (target == '0) ? OFF : ON;
        end
      end
      default: state_d = OFF;
    endcase
  end

  always_comb begin
    timer_d = '0;
    if (state_d == state_q && (state_q == UP || state_q == DOWN) && !expire)
      timer_d = timer_q + T_ONE;
  end

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  assign sq   = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};
  assign duty = sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign duty = level_q;
`endif

  assign pwm_cnt_d = pwm_cnt_q + ONE;
  assign led_d     = (pwm_cnt_q < duty);
  assign busy_d    = (state_d == UP) || (state_d == DOWN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= OFF;
      level_q     <= '0;
      pwm_cnt_q   <= '0;
      timer_q     <= '0;
      led_q       <= 1'b0;
      busy_q      <= 1'b0;
      reset_ack_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      pwm_cnt_q   <= pwm_cnt_d;
      timer_q     <= timer_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
      reset_ack_q <= 1'b0;
    end
  end

  assign reset__ack = reset_ack_q;
  assign led        = led_q;
  assign level      = level_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Scoreboarded bench for led_fade_pwm: a direction/step-count model predicts every cycle's outputs.
module tb_led_fade_pwm;

  localparam int PB = 8;
  localparam int S  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          reset__ack;
  logic          led_in = 1'b0;
  logic [PB-1:0] level_max = '0;
  logic          led;
  logic [PB-1:0] level;
  logic          busy;

  led_fade_pwm #(.PWM_BITS(PB), .STEP_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .reset__ack(reset__ack), .led_in(led_in),
    .level_max(level_max), .led(led), .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lvl;
    bit busy;
    bit led;
    bit ack;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference: level, ramp direction (+1/-1/0) and cycles since the last step/turn.
  int m_lvl = 0, m_dir = 0, m_cnt = 0, m_pc = 0;
  bit m_led = 0, m_ack = 1;

  task automatic chk(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic int duty_of(input int l);
`ifdef LED_FADE_GAMMA_EN
    return (l * l) >> PB;
`else
    return l;
`endif
  endfunction

  task automatic model_edge(input bit r, input bit li, input int lm);
    int tgt, nd;
    exp_t e;
    if (r) begin
      m_lvl = 0; m_dir = 0; m_cnt = 0; m_pc = 0; m_led = 0; m_ack = 1;
    end else begin
      m_led = (m_pc < duty_of(m_lvl));
      m_pc  = (m_pc + 1) % (1 << PB);
      m_ack = 0;
      tgt   = li ? lm : 0;
      nd    = (tgt > m_lvl) ? 1 : (tgt < m_lvl) ? -1 : 0;
      if (nd != m_dir) begin
        m_dir = nd;
        m_cnt = 0;
      end else if (m_dir != 0) begin
        m_cnt++;
        if (m_cnt == S) begin
          m_lvl += m_dir;
          m_cnt = 0;
          if (m_lvl == tgt) m_dir = 0;
        end
      end
    end
    e.lvl = m_lvl; e.busy = (m_dir != 0); e.led = m_led; e.ack = m_ack;
    q.push_back(e);
  endtask

  task automatic drive(input bit r, input bit li, input int lm);
    @(negedge clk);
    reset = r; led_in = li; level_max = PB'(lm);
    model_edge(r, li, lm);
  endtask

  task automatic run(input bit li, input int lm, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, li, lm);
  endtask

  // Ramp until the model reaches a level; bounded so a stuck ramp cannot hang the bench.
  task automatic run_until(input int lm, input int lvl_goal);
    int k;
    k = 0;
    while (m_lvl != lvl_goal && k < 2000) begin
      drive(1'b0, 1'b1, lm);
      k++;
    end
    chk("ramp_reaches_goal", m_lvl, lvl_goal);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("level", int'(level), e.lvl);
        chk("busy", int'(busy), int'(e.busy));
        chk("led", int'(led), int'(e.led));
        chk("reset__ack", int'(reset__ack), int'(e.ack));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit li;
    int lm;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 0);
    run(1'b0, 0, 4);
    run(1'b1, 8, 40 + 3 * 256);                 // fade-in to 8 then steady PWM
    run(1'b0, 8, 40);                           // fade-out to 0
    run_until(8, 5);
    run(1'b0, 8, 40);                           // reversal at 5
    run(1'b1, 0, 300);                          // zero target stays off
    run(1'b1, 255, 255 * S + 3 * 256);          // full-scale ramp and saturation
    drive(1'b1, 1'b0, 0);
    run_until(100, 3);
    drive(1'b1, 1'b1, 100);                     // reset mid-ramp
    run(1'b1, 100, 40);
    li = 1'b1; lm = 20;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(39) == 0) li = ~li;
      if ($urandom_range(59) == 0) lm = $urandom_range(255);
      if ($urandom_range(24) == 0) lm = $urandom_range(12);
      drive($urandom_range(499) == 0, li, lm);
    end
    @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
